// File: rtl/ofm_pack_writer_pkg.sv
// Shared types and constants for the OFM pack writer: FSM states, pixel
// layout and the byte-to-word packing helper.
package ofm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int PE_NUM          = 16;
  localparam int BYTES_PER_WORD  = 4;
  localparam int WORDS_PER_PIXEL = 4;

  // ch[0] sits in the top byte so a plain {ofm_active_0..15} concat is a pixel
  typedef logic [PE_NUM*8-1:0] pixel_t;

  function automatic logic [31:0] pack_word(input pixel_t p, input logic [1:0] w);
    logic [1:0] sel;
    sel = 2'd3 - w;
    return p[{sel, 5'd0} +: 32];
  endfunction

endpackage

// File: rtl/ofm_pack_writer_if.sv
// OFM BRAM write port: registered request/address/data with a ready handshake.
interface ofm_pack_writer_if #(
  parameter int ADDR_W = 20
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              wr_ready;

  modport master (output wr_en, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_en, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/ofm_pack_writer_fifo.sv
// Two-entry pixel buffer; push while full is legal only when paired with a pop.
module ofm_pixel_fifo
  import ofm_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   flush,
  input  logic   push,
  input  logic   pop,
  input  pixel_t din,
  output pixel_t head,
  output pixel_t next,
  output logic   full,
  output logic   empty
);

  pixel_t     mem_r [2];
  logic       wr_ptr_r;
  logic       rd_ptr_r;
  logic [1:0] count_r;

  assign head  = mem_r[rd_ptr_r];
  assign next  = mem_r[~rd_ptr_r];
  assign full  = (count_r == 2'd2);
  assign empty = (count_r == 2'd0);

  // Storage, pointers and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_r[0] <= {(PE_NUM*8){1'b0}};
      mem_r[1] <= {(PE_NUM*8){1'b0}};
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else if (flush) begin
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (push) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (pop) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/ofm_pack_writer.sv
// Captures 16 activated PE bytes per pixel, buffers up to two pixels and
// streams them as four channel-interleaved 32-bit words to the OFM BRAM.
module ofm_pack_writer
  import ofm_pkg::*;
#(
  parameter int ADDR_W     = 20,
  parameter int OFM_CH     = 32,
  parameter int NUM_PIXELS = 3136,
  parameter int GRP_W      = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [GRP_W-1:0]                  group_idx,
  input  logic [ADDR_W-1:0]                 base_addr,
  input  logic [15:0]                       valid,
  input  logic [7:0]                        ofm_active_0,
  input  logic [7:0]                        ofm_active_1,
  input  logic [7:0]                        ofm_active_2,
  input  logic [7:0]                        ofm_active_3,
  input  logic [7:0]                        ofm_active_4,
  input  logic [7:0]                        ofm_active_5,
  input  logic [7:0]                        ofm_active_6,
  input  logic [7:0]                        ofm_active_7,
  input  logic [7:0]                        ofm_active_8,
  input  logic [7:0]                        ofm_active_9,
  input  logic [7:0]                        ofm_active_10,
  input  logic [7:0]                        ofm_active_11,
  input  logic [7:0]                        ofm_active_12,
  input  logic [7:0]                        ofm_active_13,
  input  logic [7:0]                        ofm_active_14,
  input  logic [7:0]                        ofm_active_15,
  ofm_pack_writer_if.master                 wr,
  output logic                              busy,
  output logic                              done,
  output logic                              overflow,
  output logic                              partial_err,
  output logic [$clog2(NUM_PIXELS+1)-1:0]   pixel_count
);

  localparam int         PIX_W     = $clog2(NUM_PIXELS + 1);
  localparam logic [1:0] LAST_WORD = 2'(WORDS_PER_PIXEL - 1);

  state_e            state_r;
  logic              wr_en_r;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [31:0]       wr_data_r;
  logic [1:0]        word_r;
  logic              busy_r;
  logic              done_r;
  logic              overflow_r;
  logic              partial_r;
  logic [PIX_W-1:0]  pixel_count_r;
  logic [GRP_W-1:0]  group_r;
  logic [ADDR_W-1:0] base_r;

  pixel_t cap_data_s;
  pixel_t head_s;
  pixel_t next_s;
  logic   full_s;
  logic   empty_s;
  logic   cap_s;
  logic   xfer_s;
  logic   last_word_s;
  logic   push_s;
  logic   pop_s;

  assign cap_data_s = {ofm_active_0,  ofm_active_1,  ofm_active_2,  ofm_active_3,
                       ofm_active_4,  ofm_active_5,  ofm_active_6,  ofm_active_7,
                       ofm_active_8,  ofm_active_9,  ofm_active_10, ofm_active_11,
                       ofm_active_12, ofm_active_13, ofm_active_14, ofm_active_15};

  // start owns the cycle: a same-cycle capture or retire is discarded by the flush
  assign cap_s       = (state_r == RUN) && !start && (valid == 16'hFFFF);
  assign xfer_s      = wr_en_r && wr.wr_ready;
  assign last_word_s = xfer_s && (word_r == LAST_WORD);
  assign pop_s       = last_word_s && !start;
  assign push_s      = cap_s && (!full_s || pop_s);

  // Word address of word w of pixel pix within the current filter group
  function automatic logic [ADDR_W-1:0] calc_addr(input logic [PIX_W-1:0] pix,
                                                  input logic [1:0] w);
    return base_r
         + ADDR_W'(pix) * ADDR_W'(OFM_CH / BYTES_PER_WORD)
         + ADDR_W'(group_r) * ADDR_W'(PE_NUM / BYTES_PER_WORD)
         + ADDR_W'(w);
  endfunction

  ofm_pixel_fifo u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (start),
    .push  (push_s),
    .pop   (pop_s),
    .din   (cap_data_s),
    .head  (head_s),
    .next  (next_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // Control FSM with registered write port, status flags and pixel counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= IDLE;
      wr_en_r       <= 1'b0;
      wr_addr_r     <= {ADDR_W{1'b0}};
      wr_data_r     <= 32'd0;
      word_r        <= 2'd0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      overflow_r    <= 1'b0;
      partial_r     <= 1'b0;
      pixel_count_r <= {PIX_W{1'b0}};
      group_r       <= {GRP_W{1'b0}};
      base_r        <= {ADDR_W{1'b0}};
    end else if (start) begin
      state_r       <= RUN;
      wr_en_r       <= 1'b0;
      wr_addr_r     <= {ADDR_W{1'b0}};
      wr_data_r     <= 32'd0;
      word_r        <= 2'd0;
      busy_r        <= 1'b1;
      done_r        <= 1'b0;
      overflow_r    <= 1'b0;
      partial_r     <= 1'b0;
      pixel_count_r <= {PIX_W{1'b0}};
      group_r       <= group_idx;
      base_r        <= base_addr;
    end else begin
      case (state_r)
        RUN: begin
          if (cap_s && full_s && !pop_s) begin
            overflow_r <= 1'b1;
          end
          if ((valid != 16'h0000) && (valid != 16'hFFFF)) begin
            partial_r <= 1'b1;
          end
          if (last_word_s) begin
            pixel_count_r <= pixel_count_r + PIX_W'(1);
            if (pixel_count_r + PIX_W'(1) == PIX_W'(NUM_PIXELS)) begin
              state_r <= DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              wr_en_r <= 1'b0;
            end else if (full_s) begin
              // second pixel already buffered: keep streaming without a bubble
              wr_en_r   <= 1'b1;
              word_r    <= 2'd0;
              wr_addr_r <= calc_addr(pixel_count_r + PIX_W'(1), 2'd0);
              wr_data_r <= pack_word(next_s, 2'd0);
            end else begin
              wr_en_r <= 1'b0;
            end
          end else if (xfer_s) begin
            word_r    <= word_r + 2'd1;
            wr_addr_r <= calc_addr(pixel_count_r, word_r + 2'd1);
            wr_data_r <= pack_word(head_s, word_r + 2'd1);
          end else if (!wr_en_r && !empty_s) begin
            wr_en_r   <= 1'b1;
            word_r    <= 2'd0;
            wr_addr_r <= calc_addr(pixel_count_r, 2'd0);
            wr_data_r <= pack_word(head_s, 2'd0);
          end
        end
        IDLE, DONE: begin
          state_r <= state_r;
        end
        default: begin
          state_r <= IDLE;
          wr_en_r <= 1'b0;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign wr.wr_en     = wr_en_r;
  assign wr.wr_addr   = wr_addr_r;
  assign wr.wr_data   = wr_data_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign overflow     = overflow_r;
  assign partial_err  = partial_r;
  assign pixel_count  = pixel_count_r;

endmodule

// File: tb/tb_ofm_pack_writer.sv
// Directed self-checking bench for ofm_pack_writer (NUM_PIXELS=3, OFM_CH=32).
module tb_ofm_pack_writer;

  localparam int ADDR_W     = 20;
  localparam int OFM_CH     = 32;
  localparam int NUM_PIXELS = 3;
  localparam int GRP_W      = 4;
  localparam int PIX_W      = $clog2(NUM_PIXELS + 1);

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [GRP_W-1:0]  group_idx = 4'd0;
  logic [ADDR_W-1:0] base_addr = 20'd0;
  logic [15:0]       valid = 16'h0000;
  logic [7:0]        act [16];
  logic              busy, done, overflow, partial_err;
  logic [PIX_W-1:0]  pixel_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [ADDR_W-1:0] log_addr [$];
  logic [31:0]       log_data [$];
  int                log_cyc  [$];

  ofm_pack_writer_if #(.ADDR_W(ADDR_W)) wr_bus ();

  ofm_pack_writer #(
    .ADDR_W(ADDR_W), .OFM_CH(OFM_CH), .NUM_PIXELS(NUM_PIXELS), .GRP_W(GRP_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .group_idx(group_idx), .base_addr(base_addr),
    .valid(valid),
    .ofm_active_0(act[0]),   .ofm_active_1(act[1]),   .ofm_active_2(act[2]),   .ofm_active_3(act[3]),
    .ofm_active_4(act[4]),   .ofm_active_5(act[5]),   .ofm_active_6(act[6]),   .ofm_active_7(act[7]),
    .ofm_active_8(act[8]),   .ofm_active_9(act[9]),   .ofm_active_10(act[10]), .ofm_active_11(act[11]),
    .ofm_active_12(act[12]), .ofm_active_13(act[13]), .ofm_active_14(act[14]), .ofm_active_15(act[15]),
    .wr(wr_bus), .busy(busy), .done(done), .overflow(overflow), .partial_err(partial_err),
    .pixel_count(pixel_count)
  );

  always #5 clk = ~clk;

  // Log every accepted BRAM write with the cycle it was accepted in
  always @(posedge clk) begin
    if (reset && wr_bus.wr_en && wr_bus.wr_ready) begin
      log_addr.push_back(wr_bus.wr_addr);
      log_data.push_back(wr_bus.wr_data);
      log_cyc.push_back(cyc);
    end
    cyc <= cyc + 1;
  end

  // Expected word w of a pixel whose PE k byte is b+k
  function automatic logic [31:0] exp_word(input logic [7:0] b, input int w);
    logic [7:0] b0;
    b0 = b + 8'(4 * w);
    return {b0, b0 + 8'd1, b0 + 8'd2, b0 + 8'd3};
  endfunction

  task automatic do_start(input logic [GRP_W-1:0] g, input logic [ADDR_W-1:0] b);
    group_idx = g;
    base_addr = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    log_addr.delete();
    log_data.delete();
    log_cyc.delete();
  endtask

  task automatic capture_pixel(input logic [7:0] b, output int cap);
    for (int k = 0; k < 16; k++) act[k] = b + 8'(k);
    valid = 16'hFFFF;
    cap = cyc;
    @(negedge clk);
    valid = 16'h0000;
  endtask

  task automatic wait_writes(input int n);
    for (int i = 0; i < 80 && log_addr.size() < n; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({wr_bus.wr_en, wr_bus.wr_addr, wr_bus.wr_data} !== 53'd0) begin
      errors++;
      $display("FAIL reset_wr: got en=%b addr=%h data=%h, expected all zero",
               wr_bus.wr_en, wr_bus.wr_addr, wr_bus.wr_data);
    end
    checks++;
    if ({busy, done, overflow, partial_err, pixel_count} !== 6'd0) begin
      errors++;
      $display("FAIL reset_status: got busy=%b done=%b ovf=%b perr=%b cnt=%0d, expected all zero",
               busy, done, overflow, partial_err, pixel_count);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_pixel();
    int cap;
    logic [31:0] exp_single [4];
    exp_single[0] = 32'h00010203;
    exp_single[1] = 32'h04050607;
    exp_single[2] = 32'h08090A0B;
    exp_single[3] = 32'h0C0D0E0F;
    wr_bus.wr_ready = 1'b1;
    do_start(4'd0, 20'd0);
    capture_pixel(8'h00, cap);
    wait_writes(4);
    checks++;
    if (log_addr.size() != 4) begin
      errors++;
      $display("FAIL single_count: got %0d writes, expected 4", log_addr.size());
    end
    for (int i = 0; i < 4; i++) begin
      if (i < log_addr.size()) begin
        checks++;
        if (log_addr[i] !== 20'(i) || log_data[i] !== exp_single[i] || log_cyc[i] != cap + 2 + i) begin
          errors++;
          $display("FAIL single_word%0d: got %h@%h cyc %0d, expected %h@%h cyc %0d",
                   i, log_data[i], log_addr[i], log_cyc[i], exp_single[i], 20'(i), cap + 2 + i);
        end
      end
    end
    checks++;
    if (pixel_count !== 2'd1 || busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL single_status: got cnt=%0d busy=%b done=%b, expected 1 1 0", pixel_count, busy, done);
    end
  endtask

  task automatic test_stall();
    int cap;
    wr_bus.wr_ready = 1'b1;
    do_start(4'd0, 20'd0);
    capture_pixel(8'hA0, cap);
    wait_writes(1);
    wr_bus.wr_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({wr_bus.wr_en, wr_bus.wr_addr, wr_bus.wr_data} !== {1'b1, 20'h00001, 32'hA4A5A6A7}) begin
        errors++;
        $display("FAIL stall_hold%0d: got en=%b %h@%h, expected en=1 a4a5a6a7@00001",
                 c, wr_bus.wr_en, wr_bus.wr_data, wr_bus.wr_addr);
      end
      @(negedge clk);
    end
    wr_bus.wr_ready = 1'b1;
    wait_writes(4);
    repeat (5) @(negedge clk);
    checks++;
    if (log_addr.size() != 4) begin
      errors++;
      $display("FAIL stall_count: got %0d writes, expected 4", log_addr.size());
    end
    for (int i = 0; i < 4; i++) begin
      if (i < log_addr.size()) begin
        checks++;
        if (log_addr[i] !== 20'(i) || log_data[i] !== exp_word(8'hA0, i)) begin
          errors++;
          $display("FAIL stall_word%0d: got %h@%h, expected %h@%h",
                   i, log_data[i], log_addr[i], exp_word(8'hA0, i), 20'(i));
        end
      end
    end
  endtask

  task automatic test_overflow();
    int cap;
    logic [7:0] b;
    wr_bus.wr_ready = 1'b0;
    do_start(4'd0, 20'd0);
    capture_pixel(8'h20, cap);
    capture_pixel(8'h40, cap);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_early: got overflow=%b, expected 0", overflow);
    end
    capture_pixel(8'h60, cap);
    checks++;
    if (overflow !== 1'b1 || log_addr.size() != 0) begin
      errors++;
      $display("FAIL ovf_set: got overflow=%b writes=%0d, expected 1 and 0", overflow, log_addr.size());
    end
    wr_bus.wr_ready = 1'b1;
    wait_writes(8);
    repeat (8) @(negedge clk);
    checks++;
    if (log_addr.size() != 8 || pixel_count !== 2'd2) begin
      errors++;
      $display("FAIL ovf_count: got %0d writes cnt=%0d, expected 8 and 2", log_addr.size(), pixel_count);
    end
    for (int i = 0; i < 8; i++) begin
      if (i < log_addr.size()) begin
        b = (i < 4) ? 8'h20 : 8'h40;
        checks++;
        if (log_addr[i] !== 20'((i / 4) * 8 + (i % 4)) || log_data[i] !== exp_word(b, i % 4)) begin
          errors++;
          $display("FAIL ovf_word%0d: got %h@%h, expected %h@%h",
                   i, log_data[i], log_addr[i], exp_word(b, i % 4), 20'((i / 4) * 8 + (i % 4)));
        end
      end
    end
  endtask

  task automatic test_partial();
    wr_bus.wr_ready = 1'b1;
    do_start(4'd0, 20'd0);
    for (int k = 0; k < 16; k++) act[k] = 8'h77;
    valid = 16'h7FFF;
    @(negedge clk);
    valid = 16'h0000;
    repeat (8) @(negedge clk);
    checks++;
    if (partial_err !== 1'b1 || log_addr.size() != 0 || pixel_count !== 2'd0 || wr_bus.wr_en !== 1'b0) begin
      errors++;
      $display("FAIL partial: got perr=%b writes=%0d cnt=%0d en=%b, expected 1 0 0 0",
               partial_err, log_addr.size(), pixel_count, wr_bus.wr_en);
    end
    do_start(4'd0, 20'd0);
    checks++;
    if (partial_err !== 1'b0 || overflow !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL restart_clear: got perr=%b ovf=%b busy=%b, expected 0 0 1", partial_err, overflow, busy);
    end
  endtask

  task automatic test_address_done();
    int cap;
    bit seen11;
    logic [ADDR_W-1:0] ea;
    seen11 = 1'b0;
    wr_bus.wr_ready = 1'b1;
    do_start(4'd1, 20'h00100);
    capture_pixel(8'h10, cap);
    repeat (5) @(negedge clk);
    capture_pixel(8'h20, cap);
    repeat (5) @(negedge clk);
    capture_pixel(8'h30, cap);
    for (int i = 0; i < 80 && log_addr.size() < 12; i++) begin
      if (log_addr.size() == 11 && !seen11) begin
        seen11 = 1'b1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL done_early: got done=%b busy=%b, expected 0 1", done, busy);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (log_addr.size() != 12 || done !== 1'b1 || busy !== 1'b0 || wr_bus.wr_en !== 1'b0 || pixel_count !== 2'd3) begin
      errors++;
      $display("FAIL done: got writes=%0d done=%b busy=%b en=%b cnt=%0d, expected 12 1 0 0 3",
               log_addr.size(), done, busy, wr_bus.wr_en, pixel_count);
    end
    for (int i = 0; i < 12; i++) begin
      if (i < log_addr.size()) begin
        ea = 20'h00100 + 20'((i / 4) * 8 + 4 + (i % 4));
        checks++;
        if (log_addr[i] !== ea || log_data[i] !== exp_word(8'(8'h10 * (i / 4 + 1)), i % 4)) begin
          errors++;
          $display("FAIL addr_word%0d: got %h@%h, expected %h@%h",
                   i, log_data[i], log_addr[i], exp_word(8'(8'h10 * (i / 4 + 1)), i % 4), ea);
        end
      end
    end
    capture_pixel(8'h90, cap);
    repeat (8) @(negedge clk);
    checks++;
    if (log_addr.size() != 12 || done !== 1'b1) begin
      errors++;
      $display("FAIL done_ignore: got writes=%0d done=%b, expected 12 and 1", log_addr.size(), done);
    end
  endtask

  task automatic test_reset_mid();
    int cap;
    wr_bus.wr_ready = 1'b1;
    do_start(4'd0, 20'd0);
    capture_pixel(8'h50, cap);
    wait_writes(1);
    reset = 1'b0;
    #1;
    checks++;
    if ({wr_bus.wr_en, wr_bus.wr_addr, wr_bus.wr_data, busy, done, overflow, partial_err, pixel_count} !== 59'd0) begin
      errors++;
      $display("FAIL reset_mid: got en=%b %h@%h busy=%b done=%b cnt=%0d, expected all zero",
               wr_bus.wr_en, wr_bus.wr_data, wr_bus.wr_addr, busy, done, pixel_count);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (log_addr.size() != 1 || wr_bus.wr_en !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_after: got writes=%0d en=%b busy=%b, expected 1 0 0",
               log_addr.size(), wr_bus.wr_en, busy);
    end
  endtask

  initial begin
    for (int k = 0; k < 16; k++) act[k] = 8'h00;
    wr_bus.wr_ready = 1'b0;
    test_reset();
    test_single_pixel();
    test_stall();
    test_overflow();
    test_partial();
    test_address_done();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
